// File: rtl/mux_serializer_4to1.sv
// 4-bit parallel-to-serial converter with valid/ready on both sides.
// The bit index (out_sel) is exported so external 4:1 muxes can share the channel.
module mux_serializer_4to1 #(
  parameter int MSB_FIRST = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_bit,
  output logic [1:0] out_sel,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic [7:0] word_cnt,
  output logic       o_dbg_state
);

  // Handshake rules (both ports): a transfer happens on a rising edge where
  // valid and ready are both high. The producer holds data stable while
  // valid=1 and ready=0. in_ready is combinational from out_ready so a new
  // word can be taken on the same edge that retires the last bit.

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam logic [1:0] SEL_FIRST = (MSB_FIRST != 0) ? 2'd3 : 2'd0;
  localparam logic [1:0] SEL_LAST  = (MSB_FIRST != 0) ? 2'd0 : 2'd3;

  state_t     r_state;
  state_t     w_next_state;
  logic [3:0] r_held;
  logic [1:0] r_sel;
  logic [7:0] r_word_cnt;

  logic       w_out_valid;
  logic       w_last;
  logic       w_bit_hs;
  logic       w_accept;
  logic [1:0] w_sel_step;

  assign w_out_valid = (r_state == ST_SHIFT);
  assign w_last      = w_out_valid && (r_sel == SEL_LAST);
  assign w_bit_hs    = w_out_valid && out_ready;
  assign in_ready    = (r_state == ST_IDLE) || (w_bit_hs && w_last);
  assign w_accept    = in_valid && in_ready;
  // Stepping past the last index wraps back to SEL_FIRST, so IDLE always
  // presents the first select value.
  assign w_sel_step  = (MSB_FIRST != 0) ? (r_sel - 2'd1) : (r_sel + 2'd1);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_next_state = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (w_bit_hs && w_last && !w_accept) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_held     <= 4'd0;
      r_sel      <= SEL_FIRST;
      r_word_cnt <= 8'd0;
    end else begin
      if (w_accept) begin
        r_held <= in_data;
        r_sel  <= SEL_FIRST;
      end else if (w_bit_hs) begin
        r_sel <= w_sel_step;
      end
      if (w_bit_hs && w_last) begin
        r_word_cnt <= r_word_cnt + 8'd1;
      end
    end
  end

  assign out_valid   = w_out_valid;
  assign out_sel     = r_sel;
  assign out_last    = w_last;
  assign out_bit     = w_out_valid & r_held[r_sel];
  assign word_cnt    = r_word_cnt;
  assign o_dbg_state = r_state;

endmodule
